cdb_broadcaster: RTL

CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

---
 rtl/cdb_broadcaster_pkg.sv | 25 ++
 rtl/cdb_broadcaster_arb.sv | 29 ++
 rtl/cdb_broadcaster.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: broadcast packet, PREG tag type and functional-unit counts.
package cdb_broadcaster_pkg;

   localparam int CDB_XLEN   = 32;
   localparam int CDB_PREG_W = 6;

   localparam int NUM_FU_ALU   = 3;
   localparam int NUM_FU_MULT  = 2;
   localparam int NUM_FU_LOAD  = 1;
   localparam int NUM_FU_STORE = 1;

   typedef logic [CDB_PREG_W-1:0] PREG;

   typedef struct packed {
      logic                valid;
      PREG                 preg;
      logic [CDB_XLEN-1:0] value;
   } CDB_PACKET;

   // Pointer width that stays legal for a single-entry arbiter.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_broadcaster_arb.sv
// Combinational round-robin arbiter: first request at or after ptr wins, one-hot grant.
module rr_arbiter
   import cdb_broadcaster_pkg::*;
#(
   parameter  int N     = 6,
   localparam int PTR_W = ptr_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = ptr;
      for (int unsigned off = 0; off < N; off++) begin
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
         idx = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: one result slot per FU source, round-robin onto a
// single registered CDB, plus registered FU-release pulses to the reservation station.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter  int N_ALU   = NUM_FU_ALU,
   parameter  int N_MULT  = NUM_FU_MULT,
   parameter  int N_LOAD  = NUM_FU_LOAD,
   parameter  int N_STORE = NUM_FU_STORE,
   parameter  int XLEN    = CDB_XLEN,
   parameter  int PREG_W  = CDB_PREG_W,
   localparam int N_SRC   = N_ALU + N_MULT + N_LOAD
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          squash,
   input  logic [N_SRC-1:0]              fu_done,
   input  logic [N_SRC-1:0][PREG_W-1:0]  fu_preg,
   input  logic [N_SRC-1:0][XLEN-1:0]    fu_value,
   output logic [N_SRC-1:0]              fu_stall,
   input  logic [N_STORE-1:0]            store_done,
   output logic                          cdb_valid,
   output logic [PREG_W-1:0]             cdb_preg,
   output logic [XLEN-1:0]               cdb_value,
   output logic [N_ALU-1:0]              free_alu,
   output logic [N_MULT-1:0]             free_mult,
   output logic [N_LOAD-1:0]             free_load,
   output logic [N_STORE-1:0]            free_store
);

   localparam int PTR_W = ptr_width(N_SRC);

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] preg;
      logic [XLEN-1:0]   value;
   } cdb_t;

   logic [N_SRC-1:0]             full_q, full_d;
   logic [N_SRC-1:0][PREG_W-1:0] preg_q, preg_d;
   logic [N_SRC-1:0][XLEN-1:0]   value_q, value_d;
   logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
   cdb_t                         cdb_q, cdb_d;
   logic [N_SRC-1:0]             free_q, free_d;
   logic [N_STORE-1:0]           free_store_q, free_store_d;
   logic [N_SRC-1:0]             grant;
   logic [PTR_W-1:0]             gnt_idx;

   rr_arbiter #(.N(N_SRC)) u_arb (
      .req   (full_q),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   // A slot being granted this cycle is free to accept the next result.
   assign fu_stall = full_q & ~grant;

   always_comb begin
      full_d       = full_q;
      preg_d       = preg_q;
      value_d      = value_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_d        = '0;
      free_d       = '0;
      free_store_d = '0;
      gnt_idx      = '0;

      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (grant[i]) gnt_idx = PTR_W'(i);
      end

      if (squash) begin
         full_d = '0;
      end else begin
         full_d = full_q & ~grant;
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (fu_done[i] && !fu_stall[i]) begin
               full_d[i]  = 1'b1;
               preg_d[i]  = fu_preg[i];
               value_d[i] = fu_value[i];
            end
         end
         if (|grant) begin
            rr_ptr_d = (gnt_idx == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            // Tag 0 means no architectural destination: consume the slot silently.
            if (preg_q[gnt_idx] != '0) begin
               cdb_d.valid = 1'b1;
               cdb_d.preg  = preg_q[gnt_idx];
               cdb_d.value = value_q[gnt_idx];
            end
         end
         free_d       = grant;
         free_store_d = store_done;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         full_q       <= '0;
         preg_q       <= '0;
         value_q      <= '0;
         rr_ptr_q     <= '0;
         cdb_q        <= '0;
         free_q       <= '0;
         free_store_q <= '0;
      end else begin
         full_q       <= full_d;
         preg_q       <= preg_d;
         value_q      <= value_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_q        <= cdb_d;
         free_q       <= free_d;
         free_store_q <= free_store_d;
      end
   end

   assign cdb_valid  = cdb_q.valid;
   assign cdb_preg   = cdb_q.preg;
   assign cdb_value  = cdb_q.value;
   assign free_alu   = free_q[N_ALU-1:0];
   assign free_mult  = free_q[N_ALU +: N_MULT];
   assign free_load  = free_q[N_ALU+N_MULT +: N_LOAD];
   assign free_store = free_store_q;

endmodule
